// File: rtl/types_pkg.sv
// Shared types and constants for the memory responder.
package types_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WAIT    = 2'd1,
    RESPOND = 2'd2
  } mem_resp_state_t;

  localparam int MEM_RESP_WAIT_DEFAULT = 2;
  localparam int MEM_RESP_DATA_W       = 16;
  localparam int MEM_RESP_ADDR_W       = 16;

  // True when no address bit at or above addr_bits is set.
  function automatic logic mem_resp_in_range(input logic [MEM_RESP_ADDR_W-1:0] addr,
                                             input int addr_bits);
    return (addr >> addr_bits) == '0;
  endfunction

endpackage

// File: rtl/mem_resp_array.sv
// Register-file storage for the responder: async reset, one write port, one read port.
module mem_resp_array
  import types_pkg::*;
#(
  parameter int ADDR_BITS = 8,
  parameter int DATA_W    = MEM_RESP_DATA_W
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 we,
  input  logic [ADDR_BITS-1:0] waddr,
  input  logic [DATA_W-1:0]    wdata,
  input  logic [ADDR_BITS-1:0] raddr,
  output logic [DATA_W-1:0]    rdata
);

  localparam int DEPTH = 1 << ADDR_BITS;

  logic [DATA_W-1:0] mem_q [DEPTH];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (we) begin
      mem_q[waddr] <= wdata;
    end
  end

  assign rdata = mem_q[raddr];

endmodule

// File: rtl/mem_responder.sv
// Request/response memory responder with fixed wait states.
// Define MEM_RESPONDER_BOUNDS_CHECK_EN for out-of-range address rejection and addr_err.
//
// state   | meaning
// IDLE    | ready for a request unless halt_sys
// WAIT    | counting down wait states for the accepted request
// RESPOND | storage access done, rsp_valid high for this one cycle
module mem_responder
  import types_pkg::*;
#(
  parameter int WAIT_CYCLES = MEM_RESP_WAIT_DEFAULT,
  parameter int ADDR_BITS   = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  input  logic        req_write,
  input  logic [15:0] req_addr,
  input  logic [15:0] req_wdata,
  input  logic        halt_sys,
  output logic        req_ready,
  output logic        rsp_valid,
  output logic [15:0] rsp_rdata,
  output logic        busy,
  output logic        stall
`ifdef MEM_RESPONDER_BOUNDS_CHECK_EN
  ,
  output logic        addr_err
`endif
);

  localparam logic [3:0] WAIT_LOAD = 4'((WAIT_CYCLES > 0) ? WAIT_CYCLES - 1 : 0);

  mem_resp_state_t state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        write_q;
  logic [15:0] addr_q, wdata_q;
  logic [15:0] rdata_q, rdata_d;
  logic        err_q;
  logic        accept, enter_rsp;
  logic        txn_write, txn_ok, mem_we;
  logic [15:0] txn_addr, txn_wdata, mem_rdata;

  assign req_ready = (state_q == IDLE) && !halt_sys && !rst;
  assign accept    = req_valid && req_ready;
  assign stall     = req_valid && !req_ready;
  assign busy      = (state_q != IDLE);
  assign rsp_valid = (state_q == RESPOND);
  assign rsp_rdata = rdata_q;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    enter_rsp = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          if (WAIT_CYCLES == 0) begin
            state_d   = RESPOND;
            enter_rsp = 1'b1;
          end else begin
            state_d = WAIT;
            cnt_d   = WAIT_LOAD;
          end
        end
      end
      WAIT: begin
        if (cnt_q == 4'd0) begin
          state_d   = RESPOND;
          enter_rsp = 1'b1;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      RESPOND: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // With zero wait states the storage access happens on the accept edge itself,
  // before the request registers hold the new transaction.
  assign txn_write = (state_q == IDLE) ? req_write : write_q;
  assign txn_addr  = (state_q == IDLE) ? req_addr  : addr_q;
  assign txn_wdata = (state_q == IDLE) ? req_wdata : wdata_q;

`ifdef MEM_RESPONDER_BOUNDS_CHECK_EN
  assign txn_ok   = mem_resp_in_range(txn_addr, ADDR_BITS);
  assign addr_err = err_q;
`else
  logic unused_addr_hi;
  assign txn_ok         = 1'b1;
  assign unused_addr_hi = ^(txn_addr >> ADDR_BITS);
`endif

  assign mem_we = enter_rsp && txn_write && txn_ok;

  always_comb begin
    rdata_d = rdata_q;
    if (enter_rsp) begin
      if (txn_write)   rdata_d = txn_wdata;
      else if (txn_ok) rdata_d = mem_rdata;
      else             rdata_d = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      write_q <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rdata_q <= rdata_d;
      err_q   <= enter_rsp && !txn_ok;
      if (accept) begin
        write_q <= req_write;
        addr_q  <= req_addr;
        wdata_q <= req_wdata;
      end
    end
  end

  mem_resp_array #(
    .ADDR_BITS(ADDR_BITS),
    .DATA_W   (16)
  ) u_array (
    .clk  (clk),
    .rst  (rst),
    .we   (mem_we),
    .waddr(txn_addr[ADDR_BITS-1:0]),
    .wdata(txn_wdata),
    .raddr(txn_addr[ADDR_BITS-1:0]),
    .rdata(mem_rdata)
  );

endmodule

// File: tb/tb_mem_responder.sv
// Self-checking bench for mem_responder: one instance with 2 wait states, one with 0.
module tb_mem_responder;

  logic        clk = 1'b0;
  logic        rst, sel;
  logic        req_valid, req_write, halt_sys;
  logic [15:0] req_addr, req_wdata;

  logic        v2, h2, rdy2, rv2, busy2, stall2;
  logic        v0, h0, rdy0, rv0, busy0, stall0;
  logic [15:0] rd2, rd0;
  logic        rdy, rv, busy, stall, err;
  logic [15:0] rdata;

  int checks   = 0;
  int failures = 0;

  logic [15:0] mref [2][256];

  always #5 clk = ~clk;

  assign v2 = req_valid & ~sel;
  assign h2 = halt_sys & ~sel;
  assign v0 = req_valid & sel;
  assign h0 = halt_sys & sel;

  assign rdy   = sel ? rdy0   : rdy2;
  assign rv    = sel ? rv0    : rv2;
  assign busy  = sel ? busy0  : busy2;
  assign stall = sel ? stall0 : stall2;
  assign rdata = sel ? rd0    : rd2;

`ifdef MEM_RESPONDER_BOUNDS_CHECK_EN
  logic err2, err0;
  assign err = sel ? err0 : err2;
`else
  assign err = 1'b0;
`endif

  mem_responder #(.WAIT_CYCLES(2), .ADDR_BITS(8)) dut2 (
    .clk(clk), .rst(rst), .req_valid(v2), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata), .halt_sys(h2),
    .req_ready(rdy2), .rsp_valid(rv2), .rsp_rdata(rd2), .busy(busy2), .stall(stall2)
`ifdef MEM_RESPONDER_BOUNDS_CHECK_EN
    , .addr_err(err2)
`endif
  );

  mem_responder #(.WAIT_CYCLES(0), .ADDR_BITS(8)) dut0 (
    .clk(clk), .rst(rst), .req_valid(v0), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata), .halt_sys(h0),
    .req_ready(rdy0), .rsp_valid(rv0), .rsp_rdata(rd0), .busy(busy0), .stall(stall0)
`ifdef MEM_RESPONDER_BOUNDS_CHECK_EN
    , .addr_err(err0)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic clear_model();
    for (int s = 0; s < 2; s++)
      for (int i = 0; i < 256; i++) mref[s][i] = 16'h0000;
  endtask

  function automatic bit out_of_range(input logic [15:0] a);
`ifdef MEM_RESPONDER_BOUNDS_CHECK_EN
    return a[15:8] != 8'h00;
`else
    return 1'b0;
`endif
  endfunction

  // Called just after a falling edge with the selected responder idle.
  task automatic txn(input bit wr, input logic [15:0] a, input logic [15:0] d,
                     input bit hold, input bit halt_mid);
    int          w   = sel ? 0 : 2;
    int          idx = int'(a[7:0]);
    bit          oor = out_of_range(a);
    logic [15:0] exp_rd;
    if (wr) begin
      exp_rd = d;
      if (!oor) mref[int'(sel)][idx] = d;
    end else begin
      exp_rd = oor ? 16'h0000 : mref[int'(sel)][idx];
    end
    req_valid = 1'b1; req_write = wr; req_addr = a; req_wdata = d;
    #1;
    chk("accept_ready", rdy, 1);
    chk("accept_stall", stall, 0);
    chk("accept_busy", busy, 0);
    for (int k = 1; k <= w + 1; k++) begin
      @(negedge clk);
      if (halt_mid && k == 1) halt_sys = 1'b1;
      if (!hold) begin
        req_valid = 1'($urandom_range(0, 1));
        req_write = 1'($urandom_range(0, 1));
        req_addr  = 16'($urandom);
        req_wdata = 16'($urandom);
      end
      #1;
      chk("busy_in_txn", busy, 1);
      chk("ready_in_txn", rdy, 0);
      chk("stall_in_txn", stall, req_valid);
      chk("rsp_valid_timing", rv, (k == w + 1));
      if (k == w + 1) begin
        chk("rsp_rdata", rdata, exp_rd);
        chk("addr_err", err, oor);
      end
    end
    @(negedge clk);
    req_valid = 1'b0;
    #1;
    chk("rsp_valid_after", rv, 0);
    chk("busy_after", busy, 0);
    chk("rdata_hold", rdata, exp_rd);
    chk("ready_after", rdy, !halt_sys);
  endtask

  initial begin
    logic [15:0] a, exp_rd;
    clear_model();
    rst = 1'b1; sel = 1'b0; req_valid = 1'b0; req_write = 1'b0;
    req_addr = '0; req_wdata = '0; halt_sys = 1'b0;
    #1;
    chk("rst_rsp_valid", rv, 0);
    chk("rst_busy", busy, 0);
    chk("rst_ready", rdy, 0);
    chk("rst_rdata", rdata, 16'h0000);
    chk("rst_stall", stall, 0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    // first edge after reset accepts; then write/read of 0x12
    txn(1'b1, 16'h0012, 16'hBEEF, 1'b0, 1'b0);
    txn(1'b0, 16'h0012, 16'h0000, 1'b1, 1'b0);

    // upper address bits: wrap or reject
    txn(1'b1, 16'h0005, 16'h5555, 1'b0, 1'b0);
    txn(1'b1, 16'h0105, 16'hAAAA, 1'b0, 1'b0);
    txn(1'b0, 16'h0005, 16'h0000, 1'b0, 1'b0);
    txn(1'b0, 16'h0105, 16'h0000, 1'b0, 1'b0);

    // halt raised mid-transaction
    txn(1'b0, 16'h0012, 16'h0000, 1'b1, 1'b1);
    req_valid = 1'b1; req_write = 1'b0; req_addr = 16'h0012;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      #1;
      chk("halt_ready", rdy, 0);
      chk("halt_stall", stall, 1);
      chk("halt_busy", busy, 0);
      chk("halt_rsp_valid", rv, 0);
    end
    halt_sys = 1'b0;
    #1;
    chk("unhalt_ready", rdy, 1);
    req_valid = 1'b0;

    // reset while a write waits
    @(negedge clk);
    req_valid = 1'b1; req_write = 1'b1; req_addr = 16'h0005; req_wdata = 16'h1234;
    @(negedge clk);
    req_valid = 1'b0;
    #1;
    chk("pre_rst_busy", busy, 1);
    rst = 1'b1;
    clear_model();
    #1;
    chk("async_rst_busy", busy, 0);
    chk("async_rst_rsp_valid", rv, 0);
    chk("async_rst_rdata", rdata, 16'h0000);
    chk("async_rst_ready", rdy, 0);
    @(negedge clk);
    rst = 1'b0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      #1;
      chk("post_rst_no_rsp", rv, 0);
      chk("post_rst_busy", busy, 0);
    end
    txn(1'b0, 16'h0005, 16'h0000, 1'b0, 1'b0);

    // randomized traffic, two wait states
    for (int n = 0; n < 15; n++) begin
      a = {($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'h00, 8'($urandom_range(0, 7))};
      txn(1'($urandom_range(0, 1)), a, 16'($urandom), 1'($urandom_range(0, 1)), 1'b0);
    end

    // zero wait states: back-to-back reads held valid
    sel = 1'b1;
    txn(1'b1, 16'h0003, 16'hC0DE, 1'b0, 1'b0);
    txn(1'b1, 16'h0103, 16'h7777, 1'b0, 1'b0);
    req_valid = 1'b1; req_write = 1'b0;
    exp_rd = 16'h0000;
    for (int c = 0; c < 10; c++) begin
      if (c % 2 == 0) begin
        req_addr = {8'h00, 8'($urandom_range(0, 7))};
        exp_rd   = mref[1][int'(req_addr[7:0])];
      end
      #1;
      if (c % 2 == 0) begin
        chk("b2b_ready", rdy, 1);
        chk("b2b_stall", stall, 0);
        chk("b2b_rsp_valid", rv, 0);
      end else begin
        chk("b2b_ready", rdy, 0);
        chk("b2b_stall", stall, 1);
        chk("b2b_rsp_valid", rv, 1);
        chk("b2b_rdata", rdata, exp_rd);
      end
      @(negedge clk);
    end
    req_valid = 1'b0;
    #1;

    // randomized traffic, zero wait states
    for (int n = 0; n < 15; n++) begin
      a = {($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'h00, 8'($urandom_range(0, 7))};
      txn(1'($urandom_range(0, 1)), a, 16'($urandom), 1'($urandom_range(0, 1)), 1'b0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "time limit reached");
  end

endmodule
